// File: rtl/cbd_collector.sv
// cbd_collector: compacts accepted CBD lane samples into a FIFO and
// streams N_COEFFS coefficients; optional macro CBD_COLLECT_MODQ_EN.
module cbd_collector #(
   parameter int LANES      = 4,
   parameter int CAND_BITS  = 4,
   parameter int N_COEFFS   = 256,
   parameter int FIFO_DEPTH = 16,
`ifdef CBD_COLLECT_MODQ_EN
   localparam int COEF_W    = 12,
`else
   localparam int COEF_W    = CAND_BITS,
`endif
   localparam int IDX_W     = $clog2(N_COEFFS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       in_valid,
   input  logic [LANES*CAND_BITS-1:0] in_vals,
   input  logic [LANES-1:0]           in_accept,
   output logic                       in_ready,
   output logic [COEF_W-1:0]          coef_out,
   output logic [IDX_W-1:0]           coef_index,
   output logic                       coef_valid,
   input  logic                       coef_ready,
   output logic                       busy,
   output logic                       poly_done,
   output logic                       overflow
);

   localparam int CNT_W = $clog2(N_COEFFS + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int LN_W  = $clog2(LANES + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]        state;
   logic [COEF_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [OCC_W-1:0]  occ;
   logic [CNT_W-1:0]  wcount;
   logic [CNT_W-1:0]  rcount;
   logic [CNT_W-1:0]  room;
   logic [LN_W-1:0]   pos [LANES];
   logic [LN_W-1:0]   n_acc;
   logic [LN_W-1:0]   n_wr;
   logic [LN_W-1:0]   wr_n;
   logic              beat;
   logic              pop;
   logic              last_pop;

   function automatic logic [COEF_W-1:0] conv(input logic [CAND_BITS-1:0] s);
`ifdef CBD_COLLECT_MODQ_EN
      logic signed [12:0] v;
      v = 13'($signed(s));
      if (v < 0)
         v = v + 13'sd3329;
      return v[11:0];
`else
      return s;
`endif
   endfunction

   // slot offset of each accepted lane and the number written this beat
   always_comb begin
      n_acc = '0;
      for (int i = 0; i < LANES; i++) begin
         pos[i] = n_acc;
         n_acc  = n_acc + LN_W'(in_accept[i]);
      end
      room = CNT_W'(N_COEFFS) - wcount;
      n_wr = (CNT_W'(n_acc) > room) ? LN_W'(room) : n_acc;
   end

   assign busy       = (state != S_IDLE);
   assign in_ready   = (state == S_FILL) &&
                       ((OCC_W'(FIFO_DEPTH) - occ) >= OCC_W'(LANES));
   assign coef_valid = (occ != '0) && busy;
   assign beat       = in_valid && in_ready;
   assign pop        = coef_valid && coef_ready;
   assign wr_n       = beat ? n_wr : '0;
   assign last_pop   = pop && (rcount == CNT_W'(N_COEFFS - 1));
   assign coef_out   = coef_valid ? mem[rptr] : '0;
   assign coef_index = rcount[IDX_W-1:0];

   // compacted write of accepted lanes into free FIFO slots
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (beat && in_accept[i] && (pos[i] < n_wr))
            mem[PTR_W'(wptr + PTR_W'(pos[i]))] <=
               conv(in_vals[i*CAND_BITS +: CAND_BITS]);
      end
   end

   // control FSM, pointers, counts and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         wptr      <= '0;
         rptr      <= '0;
         occ       <= '0;
         wcount    <= '0;
         rcount    <= '0;
         overflow  <= 1'b0;
         poly_done <= 1'b0;
      end else begin
         poly_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_FILL;
                  wptr     <= '0;
                  rptr     <= '0;
                  occ      <= '0;
                  wcount   <= '0;
                  rcount   <= '0;
                  overflow <= 1'b0;
               end
            end
            S_FILL: begin
               if (wcount + CNT_W'(wr_n) == CNT_W'(N_COEFFS))
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (last_pop) begin
                  state     <= S_IDLE;
                  poly_done <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (state != S_IDLE) begin
            if (in_valid && !in_ready)
               overflow <= 1'b1;
            wptr   <= wptr + PTR_W'(wr_n);
            wcount <= wcount + CNT_W'(wr_n);
            occ    <= occ + OCC_W'(wr_n) - OCC_W'(pop);
            if (pop) begin
               rptr   <= rptr + 1'b1;
               rcount <= rcount + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_cbd_collector.sv
// tb_cbd_collector: vector table, directed sequences and a
// queue-based reference model for cbd_collector.
module tb_cbd_collector;

`ifdef CBD_COLLECT_MODQ_EN
   localparam int COEF_W = 12;
`else
   localparam int COEF_W = 4;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [15:0]       in_vals;
   logic [3:0]        in_accept;
   logic              in_ready;
   logic [COEF_W-1:0] coef_out;
   logic [7:0]        coef_index;
   logic              coef_valid;
   logic              coef_ready;
   logic              busy;
   logic              poly_done;
   logic              overflow;

   int checks = 0;
   int errors = 0;

   int q[$];
   int wcnt;
   int rcnt;
   bit active;
   bit filling;
   bit ovf_m;
   bit done_exp;

   typedef struct {
      logic [15:0] vals;
      logic [3:0]  acc;
      int          n;
      logic [3:0]  e0;
      logic [3:0]  e1;
   } vec_t;

   always #5 clk = ~clk;

   cbd_collector dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_vals    (in_vals),
      .in_accept  (in_accept),
      .in_ready   (in_ready),
      .coef_out   (coef_out),
      .coef_index (coef_index),
      .coef_valid (coef_valid),
      .coef_ready (coef_ready),
      .busy       (busy),
      .poly_done  (poly_done),
      .overflow   (overflow)
   );

   function automatic int conv(input logic [3:0] s);
`ifdef CBD_COLLECT_MODQ_EN
      int v;
      v = int'($signed(s));
      return (v < 0) ? v + 3329 : v;
`else
      return int'(s);
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      reset      = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b0;
      coef_ready = 1'b0;
      in_vals    = '0;
      in_accept  = '0;
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_coef_out", coef_out, 0);
      chk("rst_coef_index", coef_index, 0);
      chk("rst_coef_valid", coef_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_poly_done", poly_done, 0);
      chk("rst_overflow", overflow, 0);
      reset = 1'b0;
   endtask

   // mode 0 full beats, 1 write cap, 2 random, 3 backpressure,
   // 4 abort after 100 written coefficients
   task automatic run_poly(input int mode);
      int cyc   = 0;
      int beats = 0;
      int pops  = 0;
      int dones = 0;
      bit extra = 0;
      bit exp_ready;
      bit exp_valid;
      bit act_pre;
      start    = 1'b1;
      in_valid = 1'b0;
      tick();
      start = 1'b0;
      q.delete();
      wcnt     = 0;
      rcnt     = 0;
      active   = 1;
      filling  = 1;
      ovf_m    = 0;
      done_exp = 0;
      while ((active || done_exp) && cyc < 8000) begin
         if (mode == 4 && wcnt >= 100)
            break;
         in_valid   = 1'b0;
         coef_ready = 1'b1;
         in_accept  = 4'($urandom);
         in_vals    = 16'($urandom);
         case (mode)
            2: begin
               in_valid   = ($urandom_range(3) != 0);
               coef_ready = ($urandom_range(2) != 0);
            end
            3: begin
               coef_ready = (cyc >= 8);
               in_valid   = (cyc < 5) ||
                            (cyc >= 8 && cyc % 4 == 0 && filling);
               in_accept  = 4'hF;
            end
            default: begin
               in_valid  = (cyc % 4 == 0) &&
                           (beats < ((mode == 1) ? 65 : 64));
               in_accept = (mode == 1 && beats == 63) ? 4'h3 : 4'hF;
               if (mode == 1 && beats == 65 && !extra) begin
                  in_valid = 1'b1;
                  extra    = 1;
               end
            end
         endcase
         if (mode != 2)
            for (int l = 0; l < 4; l++)
               in_vals[l*4 +: 4] = 4'(4 * beats + l);
         exp_ready = filling && (16 - q.size()) >= 4;
         exp_valid = active && q.size() > 0;
         chk("in_ready", in_ready, exp_ready);
         chk("coef_valid", coef_valid, exp_valid);
         chk("busy", busy, active);
         chk("overflow", overflow, ovf_m);
         chk("poly_done", poly_done, done_exp);
         if (exp_valid) begin
            chk("coef_out", coef_out, q[0]);
            chk("coef_index", coef_index, rcnt);
         end
         act_pre  = active;
         done_exp = 0;
         if (exp_valid && coef_ready) begin
            void'(q.pop_front());
            rcnt++;
            pops++;
            if (rcnt == 256) begin
               active   = 0;
               done_exp = 1;
            end
         end
         if (in_valid) begin
            if (exp_ready) begin
               for (int l = 0; l < 4; l++)
                  if (in_accept[l] && wcnt < 256) begin
                     q.push_back(conv(in_vals[l*4 +: 4]));
                     wcnt++;
                  end
               if (wcnt == 256)
                  filling = 0;
            end else if (act_pre) begin
               ovf_m = 1;
            end
            beats++;
         end
         tick();
         cyc++;
         if (poly_done)
            dones++;
      end
      in_valid = 1'b0;
      if (mode != 4) begin
         chk("poly_in_budget", cyc < 8000, 1);
         chk("pop_total", pops, 256);
         chk("done_pulses", dones, 1);
         chk("done_single_cycle", poly_done, 0);
         chk("busy_after_done", busy, 0);
         if (mode == 1 || mode == 3)
            chk("overflow_sticky", overflow, 1);
      end
   endtask

   initial begin
      vec_t vt[6];
      int ridx;
      int got;
      vt[0] = '{16'h1234, 4'b1010, 2, 4'h3, 4'h1};
      vt[1] = '{16'h000E, 4'b0001, 1, 4'hE, 4'h0};
      vt[2] = '{16'hFFFF, 4'b0000, 0, 4'h0, 4'h0};
      vt[3] = '{16'h8F70, 4'b1111, 4, 4'h0, 4'h7};
      vt[4] = '{16'h9ABC, 4'b0100, 1, 4'hA, 4'h0};
      vt[5] = '{16'h5006, 4'b1001, 2, 4'h6, 4'h5};

      reset_dut();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_in_ready", in_ready, 1);
      coef_ready = 1'b1;
      ridx = 0;
      foreach (vt[k]) begin
         in_vals   = vt[k].vals;
         in_accept = vt[k].acc;
         in_valid  = 1'b1;
         tick();
         in_valid = 1'b0;
         chk("vec_latency", coef_valid, vt[k].n != 0);
         got = 0;
         for (int c = 0; c < 6; c++) begin
            if (coef_valid) begin
               if (got == 0)
                  chk("vec_first", coef_out, conv(vt[k].e0));
               if (got == 1)
                  chk("vec_second", coef_out, conv(vt[k].e1));
               chk("vec_index", coef_index, ridx);
               ridx++;
               got++;
            end
            tick();
         end
         chk("vec_count", got, vt[k].n);
      end

      reset_dut();
      run_poly(0);
      run_poly(3);
      run_poly(1);
      run_poly(4);
      reset_dut();
      run_poly(0);

      in_valid  = 1'b1;
      in_accept = 4'hF;
      tick();
      chk("idle_no_overflow", overflow, 0);
      chk("idle_in_ready", in_ready, 0);
      in_valid = 1'b0;
      for (int r = 0; r < 3; r++)
         run_poly(2);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
